bmain_arbiter: RTL and testbench

- Shares the single main-bus slave port between two requesters.
- Requester fe1 is the instruction-cache refill path and issues reads only.
- Requester mem1 is the data-cache evict/fill path and issues reads and writes.
- Ownership is held from command grant until the burst's last beat or an acknowledged error. Response data is broadcast; valid/ready/error handshakes are routed to the owner only.

---
 rtl/bmain_pkg.sv | 31 +++
 rtl/bmain_grant_pick.sv | 40 ++++
 rtl/bmain_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_bmain_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmain_pkg.sv
// Purpose: shared types and constants for the main-bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bmain_pkg;

    typedef enum logic {
        FE1  = 1'b0,
        MEM1 = 1'b1
    } bmain_owner_t;

    // One-hot arbiter state; exactly one field is set in a legal encoding.
    typedef struct packed {
        logic idle;
        logic cmd;
        logic write;
        logic read;
    } bmain_arb_state_t;

    localparam logic BMAIN_CMD_READ  = 1'b1;
    localparam logic BMAIN_CMD_WRITE = 1'b0;

    localparam bmain_arb_state_t ST_IDLE  = 4'b1000;
    localparam bmain_arb_state_t ST_CMD   = 4'b0100;
    localparam bmain_arb_state_t ST_WRITE = 4'b0010;
    localparam bmain_arb_state_t ST_READ  = 4'b0001;

    function automatic bmain_owner_t bmain_other(input bmain_owner_t o);
        return (o == FE1) ? MEM1 : FE1;
    endfunction

endpackage

// File: rtl/bmain_grant_pick.sv
// Purpose: pick the winner between fe1 and mem1 command requests (BMAIN_RR_EN selects round-robin tie-break).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; caller decides when the pick is used.
module bmain_grant_pick
    import bmain_pkg::*;
(
    input  logic         i_fe1_req,
    input  logic         i_mem1_req,
    input  bmain_owner_t i_last_owner,
    input  logic         i_starved,
    output logic         o_vld,
    output bmain_owner_t o_owner
);

`ifdef BMAIN_RR_EN
    // Round-robin ignores starvation; the counter is held at zero by the parent.
    logic w_unused_starved;
    assign w_unused_starved = i_starved;
`else
    // Fixed priority does not need history of the previous owner.
    logic w_unused_last;
    assign w_unused_last = (i_last_owner == MEM1);
`endif

    // Winner selection: single requester wins outright, ties go to the mode's rule.
    always_comb begin
        o_vld   = i_fe1_req | i_mem1_req;
        o_owner = MEM1;
        if (i_fe1_req && !i_mem1_req) begin
            o_owner = FE1;
        end else if (i_fe1_req && i_mem1_req) begin
`ifdef BMAIN_RR_EN
            o_owner = bmain_other(i_last_owner);
`else
            o_owner = i_starved ? FE1 : MEM1;
`endif
        end
    end

endmodule

// File: rtl/bmain_arbiter.sv
// Purpose: share one main-bus slave port between fe1 (reads) and mem1 (reads/writes); BMAIN_RR_EN enables round-robin.
// Latency: 0 cycles, combinational routing; only state, owner and starvation counter are registered.
// Backpressure: slave cready/wready/rvalid and owner rready pass straight through to the current owner only.
module bmain_arbiter
    import bmain_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_W     = 3
) (
    input  logic        clk_core,
    input  logic        reset,
    // fe1: instruction-cache refill, reads only
    input  logic        fe1_cvalid,
    output logic        bmain_cready_fe1,
    input  logic [26:0] fe1_bus_addr,
    output logic        bmain_rvalid_fe1,
    input  logic        fe1_rready,
    output logic        bmain_error_fe1,
    input  logic        fe1_eack,
    // mem1: data-cache evict/fill
    input  logic        mem1_cvalid,
    input  logic        mem1_cmd,
    input  logic [26:0] mem1_bus_addr,
    output logic        bmain_cready_mem1,
    input  logic        mem1_wvalid,
    input  logic        mem1_wlast,
    input  logic [31:0] mem1_bus_wdata,
    input  logic [3:0]  mem1_wmask,
    output logic        bmain_wready_mem1,
    output logic        bmain_rvalid_mem1,
    input  logic        mem1_rready,
    output logic        bmain_error_mem1,
    input  logic        mem1_eack,
    // broadcast read data
    output logic        bmain_rlast,
    output logic [31:0] bmain_rdata,
    // slave port
    output logic        bus_cvalid,
    output logic        bus_cmd,
    output logic [26:0] bus_addr,
    input  logic        bus_cready,
    output logic        bus_wvalid,
    output logic        bus_wlast,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_wready,
    input  logic        bus_rvalid,
    input  logic        bus_rlast,
    input  logic [31:0] bus_rdata,
    output logic        bus_rready,
    input  logic        bus_error,
    output logic        bus_eack
);

    localparam logic [STARVE_W-1:0] W_LIMIT = STARVE_LIMIT[STARVE_W-1:0];
    localparam logic [STARVE_W-1:0] W_SAT   = {STARVE_W{1'b1}};

    bmain_arb_state_t    r_state;
    bmain_owner_t        r_owner;
    logic [STARVE_W-1:0] r_starve_cnt;

    logic             w_starved;
    logic             w_pick_vld;
    bmain_owner_t     w_pick;
    bmain_owner_t     w_sel;
    logic             w_cmd_phase;
    logic             w_cmd_vld;
    logic             w_sel_cmd;
    logic [26:0]      w_sel_addr;
    logic             w_cmd_acc;
    logic             w_fwd_w;
    logic             w_w_acc;
    logic             w_rd_phase;
    logic             w_own_rready;
    logic             w_busy;
    logic             w_own_eack;
    logic             w_err_done;
    bmain_arb_state_t w_after_acc;

    assign w_starved = (r_starve_cnt >= W_LIMIT);

    bmain_grant_pick u_pick (
        .i_fe1_req    (fe1_cvalid),
        .i_mem1_req   (mem1_cvalid),
        .i_last_owner (r_owner),
        .i_starved    (w_starved),
        .o_vld        (w_pick_vld),
        .o_owner      (w_pick)
    );

    // Selected requester: fresh pick while idle, otherwise the latched owner.
    // Every routed output is forced low while reset is held.
    always_comb begin
        w_sel        = r_state.idle ? w_pick : r_owner;
        w_cmd_phase  = !reset && (r_state.idle || r_state.cmd);
        w_cmd_vld    = w_cmd_phase && ((w_sel == MEM1) ? mem1_cvalid : fe1_cvalid);
        w_sel_cmd    = (w_sel == FE1) ? BMAIN_CMD_READ : mem1_cmd;
        w_sel_addr   = (w_sel == FE1) ? fe1_bus_addr : mem1_bus_addr;
        w_cmd_acc    = w_cmd_vld && bus_cready;
        w_fwd_w      = !reset && ((w_cmd_vld && (w_sel == MEM1) && (w_sel_cmd == BMAIN_CMD_WRITE))
                                  || r_state.write);
        w_w_acc      = w_fwd_w && mem1_wvalid && bus_wready;
        w_rd_phase   = !reset && r_state.read;
        w_own_rready = (r_owner == MEM1) ? mem1_rready : fe1_rready;
        w_busy       = !reset && (r_state.cmd || r_state.write || r_state.read);
        w_own_eack   = (r_owner == MEM1) ? mem1_eack : fe1_eack;
        w_err_done   = w_busy && bus_error && w_own_eack;

        if (w_sel_cmd == BMAIN_CMD_READ) begin
            w_after_acc = ST_READ;
        end else if (w_w_acc && mem1_wlast) begin
            w_after_acc = ST_IDLE;
        end else begin
            w_after_acc = ST_WRITE;
        end
    end

    // Command and write channel routing toward the slave.
    assign bus_cvalid        = w_cmd_vld;
    assign bus_cmd           = w_cmd_vld && w_sel_cmd;
    assign bus_addr          = w_cmd_vld ? w_sel_addr : 27'd0;
    assign bmain_cready_fe1  = w_cmd_vld && (w_sel == FE1)  && bus_cready;
    assign bmain_cready_mem1 = w_cmd_vld && (w_sel == MEM1) && bus_cready;

    assign bus_wvalid        = w_fwd_w && mem1_wvalid;
    assign bus_wlast         = w_fwd_w && mem1_wlast;
    assign bus_wdata         = w_fwd_w ? mem1_bus_wdata : 32'd0;
    assign bus_wmask         = w_fwd_w ? mem1_wmask : 4'd0;
    assign bmain_wready_mem1 = w_fwd_w && bus_wready;

    // Read handshake goes to the owner only; data and last are broadcast.
    assign bmain_rvalid_fe1  = w_rd_phase && (r_owner == FE1)  && bus_rvalid;
    assign bmain_rvalid_mem1 = w_rd_phase && (r_owner == MEM1) && bus_rvalid;
    assign bus_rready        = w_rd_phase && w_own_rready;
    assign bmain_rdata       = bus_rdata;
    assign bmain_rlast       = bus_rlast;

    // Errors reach the owner during a transaction; an idle error is absorbed here.
    assign bmain_error_fe1   = w_busy && (r_owner == FE1)  && bus_error;
    assign bmain_error_mem1  = w_busy && (r_owner == MEM1) && bus_error;
    assign bus_eack          = w_busy ? w_own_eack : (!reset && bus_error);

    // Ownership FSM plus starvation counter.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= MEM1;
            r_starve_cnt <= '0;
        end else begin
            if (r_state.idle) begin
                if (w_pick_vld) begin
                    r_owner <= w_pick;
                    r_state <= w_cmd_acc ? w_after_acc : ST_CMD;
                end
            end else if (w_err_done) begin
                r_state <= ST_IDLE;
            end else if (r_state.cmd) begin
                if (w_cmd_acc) begin
                    r_state <= w_after_acc;
                end
            end else if (r_state.write) begin
                if (w_w_acc && mem1_wlast) begin
                    r_state <= ST_IDLE;
                end
            end else if (r_state.read) begin
                if (bus_rvalid && bus_rready && bus_rlast) begin
                    r_state <= ST_IDLE;
                end
            end else begin
                r_state <= ST_IDLE;
            end

`ifdef BMAIN_RR_EN
            r_starve_cnt <= '0;
`else
            if (w_cmd_acc && fe1_cvalid && (w_sel == MEM1)) begin
                if (r_starve_cnt != W_SAT) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else if (r_state.idle && w_pick_vld && (w_pick == FE1)) begin
                r_starve_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bmain_arbiter.sv
// Directed bench for bmain_arbiter: stimulus pushes expected grants/beats into
// queues, a negedge monitor pops and compares whenever the DUT shows a handshake.
module tb_bmain_arbiter;

    logic        clk_core = 1'b0;
    logic        reset;
    logic        fe1_cvalid, bmain_cready_fe1, bmain_rvalid_fe1, fe1_rready, bmain_error_fe1, fe1_eack;
    logic [26:0] fe1_bus_addr;
    logic        mem1_cvalid, mem1_cmd, bmain_cready_mem1;
    logic [26:0] mem1_bus_addr;
    logic        mem1_wvalid, mem1_wlast, bmain_wready_mem1, bmain_rvalid_mem1, mem1_rready;
    logic [31:0] mem1_bus_wdata;
    logic [3:0]  mem1_wmask;
    logic        bmain_error_mem1, mem1_eack, bmain_rlast;
    logic [31:0] bmain_rdata;
    logic        bus_cvalid, bus_cmd, bus_cready, bus_wvalid, bus_wlast, bus_wready;
    logic [26:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic [3:0]  bus_wmask;
    logic        bus_rvalid, bus_rlast, bus_rready, bus_error, bus_eack;

    always #5 clk_core = ~clk_core;

    bmain_arbiter dut (
        .clk_core(clk_core), .reset(reset),
        .fe1_cvalid(fe1_cvalid), .bmain_cready_fe1(bmain_cready_fe1), .fe1_bus_addr(fe1_bus_addr),
        .bmain_rvalid_fe1(bmain_rvalid_fe1), .fe1_rready(fe1_rready),
        .bmain_error_fe1(bmain_error_fe1), .fe1_eack(fe1_eack),
        .mem1_cvalid(mem1_cvalid), .mem1_cmd(mem1_cmd), .mem1_bus_addr(mem1_bus_addr),
        .bmain_cready_mem1(bmain_cready_mem1), .mem1_wvalid(mem1_wvalid), .mem1_wlast(mem1_wlast),
        .mem1_bus_wdata(mem1_bus_wdata), .mem1_wmask(mem1_wmask), .bmain_wready_mem1(bmain_wready_mem1),
        .bmain_rvalid_mem1(bmain_rvalid_mem1), .mem1_rready(mem1_rready),
        .bmain_error_mem1(bmain_error_mem1), .mem1_eack(mem1_eack),
        .bmain_rlast(bmain_rlast), .bmain_rdata(bmain_rdata),
        .bus_cvalid(bus_cvalid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_cready(bus_cready),
        .bus_wvalid(bus_wvalid), .bus_wlast(bus_wlast), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_wready(bus_wready), .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rdata(bus_rdata),
        .bus_rready(bus_rready), .bus_error(bus_error), .bus_eack(bus_eack)
    );

    typedef struct { logic who; logic cmd; logic [26:0] addr; } cmd_exp_t;   // who: 1 = mem1
    typedef struct { logic who; logic [31:0] data; logic last; } rd_exp_t;
    typedef struct { logic [31:0] data; logic [3:0] mask; logic last; } wr_exp_t;

    cmd_exp_t q_cmd[$];
    rd_exp_t  q_rd[$];
    wr_exp_t  q_wr[$];
    cmd_exp_t m_c;
    rd_exp_t  m_r;
    wr_exp_t  m_w;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rv_fe1 = 0;
    int n_rv_mem1 = 0;

    localparam logic [3:0] S_IDLE = 4'b1000, S_CMD = 4'b0100, S_WRITE = 4'b0010, S_READ = 4'b0001;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic miss(input string nm);
        n_chk++;
        $display("FAIL %s actual=unexpected-handshake required=none", nm);
    endtask

    function automatic logic [127:0] all_outs();
        return {bmain_cready_fe1, bmain_rvalid_fe1, bmain_error_fe1, bmain_cready_mem1,
                bmain_wready_mem1, bmain_rvalid_mem1, bmain_error_mem1, bmain_rlast, bmain_rdata,
                bus_cvalid, bus_cmd, bus_addr, bus_wvalid, bus_wlast, bus_wdata, bus_wmask,
                bus_rready, bus_eack};
    endfunction

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic quiet();
        fe1_cvalid = 0; fe1_bus_addr = '0; fe1_rready = 0; fe1_eack = 0;
        mem1_cvalid = 0; mem1_cmd = 0; mem1_bus_addr = '0; mem1_wvalid = 0; mem1_wlast = 0;
        mem1_bus_wdata = '0; mem1_wmask = '0; mem1_rready = 0; mem1_eack = 0;
        bus_cready = 0; bus_wready = 0; bus_rvalid = 0; bus_rlast = 0; bus_rdata = '0; bus_error = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic push_cmd(input logic who, input logic cmd, input logic [26:0] addr);
        cmd_exp_t e;
        e.who = who; e.cmd = cmd; e.addr = addr;
        q_cmd.push_back(e);
    endtask

    task automatic push_rd(input logic who, input logic [31:0] data, input logic last);
        rd_exp_t e;
        e.who = who; e.data = data; e.last = last;
        q_rd.push_back(e);
    endtask

    // Monitor: compares every handshake the DUT presents against the queues.
    always @(negedge clk_core) begin
        if (!reset) begin
            if (bmain_rvalid_fe1)  n_rv_fe1++;
            if (bmain_rvalid_mem1) n_rv_mem1++;
            if (bus_cvalid && bus_cready) begin
                if (q_cmd.size() == 0) miss("cmd_grant");
                else begin
                    m_c = q_cmd.pop_front();
                    chk("grant_who", {bmain_cready_mem1, bmain_cready_fe1}, m_c.who ? 2'b10 : 2'b01);
                    chk("grant_cmd", bus_cmd, m_c.cmd);
                    chk("grant_addr", bus_addr, m_c.addr);
                end
            end
            if (bus_rvalid && bus_rready) begin
                if (q_rd.size() == 0) miss("rd_beat");
                else begin
                    m_r = q_rd.pop_front();
                    chk("rd_who", {bmain_rvalid_mem1, bmain_rvalid_fe1}, m_r.who ? 2'b10 : 2'b01);
                    chk("rd_data", {bmain_rlast, bmain_rdata}, {m_r.last, m_r.data});
                end
            end
            if (bus_wvalid && bus_wready) begin
                if (q_wr.size() == 0) miss("wr_beat");
                else begin
                    m_w = q_wr.pop_front();
                    chk("wr_beat", {bmain_wready_mem1, bus_wlast, bus_wmask, bus_wdata},
                        {1'b1, m_w.last, m_w.mask, m_w.data});
                end
            end
        end
    end

    logic [31:0] wdat [4];
    logic        exp_who;
    wr_exp_t     we;

    initial begin
        wdat[0] = 32'hA0A0_0001; wdat[1] = 32'hB1B1_0002; wdat[2] = 32'hC2C2_0003; wdat[3] = 32'hD3D3_0004;
        quiet();
        reset = 1;
        fe1_cvalid = 1; fe1_bus_addr = 27'h0000123;
        tick();
        @(negedge clk_core);
        chk("reset_outs", all_outs(), '0);
        chk("reset_state", {dut.r_state, dut.r_owner, dut.r_starve_cnt}, {S_IDLE, 1'b1, 3'd0});
        do_reset();

        // fe1 read, 4 beats
        n_rv_fe1 = 0; n_rv_mem1 = 0;
        fe1_cvalid = 1; fe1_bus_addr = 27'h0001000; fe1_rready = 1; bus_cready = 1;
        push_cmd(1'b0, 1'b1, 27'h0001000);
        tick();
        chk("fe1_rd_state", dut.r_state, S_READ);
        fe1_cvalid = 0; bus_cready = 0;
        for (int i = 0; i < 4; i++) begin
            bus_rvalid = 1; bus_rdata = 32'h5500_0000 + i; bus_rlast = (i == 3);
            push_rd(1'b0, 32'h5500_0000 + i, i == 3);
            tick();
        end
        quiet();
        chk("fe1_rd_done", dut.r_state, S_IDLE);
        chk("fe1_rv_pulses", {n_rv_fe1[7:0], n_rv_mem1[7:0]}, {8'd4, 8'd0});

        // mem1 write, command stalled two cycles, wready toggling
        do_reset();
        mem1_cvalid = 1; mem1_cmd = 0; mem1_bus_addr = 27'h0ABCDEF;
        mem1_wvalid = 1; mem1_bus_wdata = wdat[0]; mem1_wmask = 4'hF; mem1_wlast = 0;
        @(negedge clk_core);
        chk("idle_c_w_fwd", {bus_cvalid, bus_wvalid, bus_cmd}, 3'b110);
        tick();
        chk("wr_cmd_state", dut.r_state, S_CMD);
        fe1_cvalid = 1; fe1_bus_addr = 27'h0000777;
        @(negedge clk_core);
        chk("cmd_no_preempt", {bus_addr, bmain_cready_fe1}, {27'h0ABCDEF, 1'b0});
        tick();
        bus_cready = 1;
        push_cmd(1'b1, 1'b0, 27'h0ABCDEF);
        tick();
        bus_cready = 0; mem1_cvalid = 0;
        chk("wr_write_state", dut.r_state, S_WRITE);
        for (int i = 0; i < 4; i++) begin
            mem1_bus_wdata = wdat[i]; mem1_wmask = 4'(i + 1); mem1_wlast = (i == 3);
            bus_wready = 0;
            tick();
            bus_wready = 1;
            we.data = wdat[i]; we.mask = 4'(i + 1); we.last = (i == 3);
            q_wr.push_back(we);
            if (i == 3) fe1_cvalid = 0;
            tick();
        end
        quiet();
        chk("wr_done_state", {dut.r_state, dut.r_starve_cnt}, {S_IDLE, 3'd1});

        // both requesting continuously
        do_reset();
        fe1_cvalid = 1; fe1_bus_addr = 27'h0000100; fe1_rready = 1;
        mem1_cvalid = 1; mem1_cmd = 1; mem1_bus_addr = 27'h0000200; mem1_rready = 1;
        bus_cready = 1;
        for (int g = 0; g < 10; g++) begin
`ifdef BMAIN_RR_EN
            exp_who = (g % 2 == 1);
`else
            exp_who = !(g == 4 || g == 9);
`endif
            push_cmd(exp_who, 1'b1, exp_who ? 27'h0000200 : 27'h0000100);
            bus_rvalid = 0; bus_rlast = 0;
            tick();
            bus_rvalid = 1; bus_rlast = 1; bus_rdata = 32'h0000_0C00 + g;
            push_rd(exp_who, 32'h0000_0C00 + g, 1'b1);
            tick();
        end
        quiet();
        chk("starve_end_state", dut.r_state, S_IDLE);

        // bus error on beat 2 of a fe1 read
        do_reset();
        fe1_cvalid = 1; fe1_bus_addr = 27'h0000040; fe1_rready = 1; bus_cready = 1;
        push_cmd(1'b0, 1'b1, 27'h0000040);
        tick();
        fe1_cvalid = 0; bus_cready = 0;
        bus_rvalid = 1; bus_rdata = 32'h1111_1111; bus_rlast = 0;
        push_rd(1'b0, 32'h1111_1111, 1'b0);
        tick();
        bus_rvalid = 0; bus_error = 1; fe1_eack = 1;
        @(negedge clk_core);
        chk("err_route", {bmain_error_fe1, bmain_error_mem1, bus_eack}, 3'b101);
        tick();
        chk("err_state", dut.r_state, S_IDLE);
        bus_error = 0; fe1_eack = 0;
        mem1_cvalid = 1; mem1_cmd = 1; mem1_bus_addr = 27'h0000300; mem1_rready = 1; bus_cready = 1;
        push_cmd(1'b1, 1'b1, 27'h0000300);
        tick();
        chk("post_err_grant", {dut.r_state, dut.r_owner}, {S_READ, 1'b1});
        mem1_cvalid = 0; bus_cready = 0;
        bus_rvalid = 1; bus_rlast = 1; bus_rdata = 32'h2222_2222;
        push_rd(1'b1, 32'h2222_2222, 1'b1);
        tick();
        quiet();
        // error while idle is absorbed
        bus_error = 1;
        @(negedge clk_core);
        chk("idle_err", {bmain_error_fe1, bmain_error_mem1, bus_eack}, 3'b001);
        tick();
        chk("idle_err_state", dut.r_state, S_IDLE);
        bus_error = 0;

        // reset mid-burst
        do_reset();
        fe1_cvalid = 1; fe1_bus_addr = 27'h0000100;
        mem1_cvalid = 1; mem1_cmd = 1; mem1_bus_addr = 27'h0000400; mem1_rready = 1; bus_cready = 1;
        push_cmd(1'b1, 1'b1, 27'h0000400);
        tick();
        mem1_cvalid = 0; bus_cready = 0;
        chk("mid_pre_cnt", {dut.r_state, dut.r_starve_cnt}, {S_READ, 3'd1});
        bus_rvalid = 1; bus_rlast = 0; bus_rdata = 32'h3333_3333;
        push_rd(1'b1, 32'h3333_3333, 1'b0);
        tick();
        reset = 1; bus_rdata = '0;
        @(negedge clk_core);
        chk("mid_reset_outs", all_outs(), '0);
        tick();
        reset = 0;
        quiet();
        @(negedge clk_core);
        chk("post_reset_outs", all_outs(), '0);
        chk("post_reset_state", {dut.r_state, dut.r_owner, dut.r_starve_cnt}, {S_IDLE, 1'b1, 3'd0});
        tick();

        chk("q_cmd_empty", q_cmd.size(), 0);
        chk("q_rd_empty", q_rd.size(), 0);
        chk("q_wr_empty", q_wr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
